// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: the mode encoding
// and small decode helpers used by both the register and the frame counter.
package usr_pkg;

   localparam int MODE_W = 3;

   // Operation codes; 3'b111 is reserved and treated as HOLD.
   typedef enum logic [MODE_W-1:0] {
      HOLD  = 3'b000,
      SHL   = 3'b001,
      SHR   = 3'b010,
      ROL   = 3'b011,
      ROR   = 3'b100,
      LOAD  = 3'b101,
      CLEAR = 3'b110
   } usr_mode_e;

   localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

   // True for the four modes that move bits and advance the frame count.
   function automatic logic is_shift(input logic [MODE_W-1:0] m);
      return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR);
   endfunction

   // True for the modes that overwrite the whole register and so start a new frame.
   function automatic logic is_reload(input logic [MODE_W-1:0] m);
      return (m == LOAD) || (m == CLEAR);
   endfunction

endpackage

// File: rtl/shift_frame_cntr.sv
// Counts enabled shift/rotate steps and pulses frame_done for one cycle on
// the WIDTH-th step of each frame. A reload (LOAD/CLEAR) discards any
// partial frame. With WIDTH=1 every step completes a frame.
module shift_frame_cntr
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic step,
   input  logic clear,
   output logic frame_done
);

   localparam int               CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             fd_next;

   // Next count and pulse: reload wins over step; the pulse is only raised on the wrap.
   always_comb begin
      cnt_next = cnt;
      fd_next  = 1'b0;
      if (clear) begin
         cnt_next = '0;
      end else if (step) begin
         if (cnt == LAST) begin
            cnt_next = '0;
            fd_next  = 1'b1;
         end else begin
            cnt_next = cnt + CNT_W'(1);
         end
      end
   end

   // Count and pulse registers, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         frame_done <= fd_next;
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right, rotate left/right,
// parallel load and clear, chosen per cycle by mode while en is high.
// Serial outputs are taken straight from the register, so they change
// together with par_out. The shift/rotate expressions are written with
// shift operators so that WIDTH=1 needs no special case.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic              ser_in,
   input  logic [WIDTH-1:0]  par_in,
   output logic [WIDTH-1:0]  par_out,
   output logic              ser_out_msb,
   output logic              ser_out_lsb,
   output logic              frame_done
);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] shl_val;
   logic [WIDTH-1:0] shr_val;
   logic [WIDTH-1:0] rol_val;
   logic [WIDTH-1:0] ror_val;
   logic             step;
   logic             clear;

   // Candidate results of the four bit-moving operations.
   always_comb begin
      shl_val = (q << 1) | WIDTH'(ser_in);
      shr_val = (q >> 1) | (WIDTH'(ser_in) << (WIDTH - 1));
      rol_val = (q << 1) | (q >> (WIDTH - 1));
      ror_val = (q >> 1) | (q << (WIDTH - 1));
   end

   // Mode mux; disabled cycles, HOLD and the reserved code keep q.
   always_comb begin
      q_next = q;
      if (en) begin
         case (mode)
            SHL:     q_next = shl_val;
            SHR:     q_next = shr_val;
            ROL:     q_next = rol_val;
            ROR:     q_next = ror_val;
            LOAD:    q_next = par_in;
            CLEAR:   q_next = '0;
            default: q_next = q;
         endcase
      end
   end

   // Data register; reset restores RESET_VAL, whereas CLEAR always writes zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RESET_VAL;
      end else begin
         q <= q_next;
      end
   end

   assign step  = en & is_shift(mode);
   assign clear = en & is_reload(mode);

   shift_frame_cntr #(
      .WIDTH (WIDTH)
   ) u_cntr (
      .clk        (clk),
      .rst        (rst),
      .step       (step),
      .clear      (clear),
      .frame_done (frame_done)
   );

   assign par_out     = q;
   assign ser_out_msb = q[WIDTH-1];
   assign ser_out_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): directed scenarios followed
// by random operations, all checked against an arithmetic reference model.
module tb_univ_shift_reg;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         en;
   logic [2:0]   mode;
   logic         ser_in;
   logic [W-1:0] par_in;
   logic [W-1:0] par_out;
   logic         ser_out_msb;
   logic         ser_out_lsb;
   logic         frame_done;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: value as an integer and a plain step counter.
   int m_q;
   int m_cnt;
   int m_fd;

   univ_shift_reg #(
      .WIDTH     (W),
      .RESET_VAL (8'h00)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .ser_in      (ser_in),
      .par_in      (par_in),
      .par_out     (par_out),
      .ser_out_msb (ser_out_msb),
      .ser_out_lsb (ser_out_lsb),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply operation rules with plain arithmetic on the model.
   task automatic model_step(input int e, input int m, input int s, input int p);
      m_fd = 0;
      if (e != 0) begin
         case (m)
            1: m_q = (m_q * 2 + s) % 256;
            2: m_q = m_q / 2 + s * 128;
            3: m_q = (m_q * 2) % 256 + m_q / 128;
            4: m_q = m_q / 2 + (m_q % 2) * 128;
            5: m_q = p;
            6: m_q = 0;
            default: ;
         endcase
         if (m >= 1 && m <= 4) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == W) begin
               m_cnt = 0;
               m_fd  = 1;
            end
         end else if (m == 5 || m == 6) begin
            m_cnt = 0;
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_q"},   par_out,     m_q);
      check({tag, "_msb"}, ser_out_msb, (m_q / 128) % 2);
      check({tag, "_lsb"}, ser_out_lsb, m_q % 2);
      check({tag, "_fd"},  frame_done,  m_fd);
   endtask

   // One clock with the given inputs, then compare against the model.
   task automatic op(input string tag, input logic e, input logic [2:0] m,
                     input logic s, input logic [W-1:0] p);
      en     = e;
      mode   = m;
      ser_in = s;
      par_in = p;
      @(posedge clk);
      #1;
      model_step(int'(e), int'(m), int'(s), int'(p));
      check_model(tag);
   endtask

   task automatic model_reset();
      m_q   = 0;
      m_cnt = 0;
      m_fd  = 0;
   endtask

   logic [W-1:0] t1_q   [8];
   logic         t1_msb [8];
   logic [W-1:0] held;

   initial begin
      t1_q   = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
      t1_msb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      // Reset state
      rst = 1'b1; en = 1'b0; mode = 3'b000; ser_in = 1'b0; par_in = '0;
      model_reset();
      #1;
      check("rst_q", par_out, 8'h00);
      check("rst_fd", frame_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // 1: LOAD A5, 8x SHL with ser_in=1
      op("t1_load", 1, 3'b101, 0, 8'hA5);
      check("t1_load_val", par_out, 8'hA5);
      for (int i = 0; i < 8; i++) begin
         op("t1_shl", 1, 3'b001, 1, 8'h00);
         check($sformatf("t1_q%0d", i), par_out, t1_q[i]);
         check($sformatf("t1_msb%0d", i), ser_out_msb, t1_msb[i]);
         check($sformatf("t1_fd%0d", i), frame_done, (i == 7) ? 1'b1 : 1'b0);
      end
      op("t1_after", 1, 3'b000, 0, 8'h00);
      check("t1_fd_drop", frame_done, 1'b0);

      // 2: rotations
      op("t2_load", 1, 3'b101, 0, 8'h81);
      op("t2_ror1", 1, 3'b100, 0, 8'h00);
      check("t2_ror1_val", par_out, 8'hC0);
      for (int i = 0; i < 7; i++) op("t2_ror", 1, 3'b100, 0, 8'h00);
      check("t2_ror8_val", par_out, 8'h81);
      check("t2_ror8_fd", frame_done, 1'b1);
      for (int i = 0; i < 8; i++) op("t2_rol", 1, 3'b011, 0, 8'h00);
      check("t2_rol8_val", par_out, 8'h81);
      check("t2_rol8_fd", frame_done, 1'b1);

      // 3: SHR in ones, CLEAR, reserved code
      op("t3_clr0", 1, 3'b110, 0, 8'h00);
      op("t3_shr1", 1, 3'b010, 1, 8'h00);
      check("t3_shr1_val", par_out, 8'h80);
      op("t3_shr2", 1, 3'b010, 1, 8'h00);
      check("t3_shr2_val", par_out, 8'hC0);
      op("t3_clear", 1, 3'b110, 0, 8'h00);
      check("t3_clear_val", par_out, 8'h00);
      op("t3_load", 1, 3'b101, 0, 8'h5A);
      op("t3_rsvd", 1, 3'b111, 1, 8'hFF);
      check("t3_rsvd_val", par_out, 8'h5A);

      // 4: frame spanning disabled gaps; disabled LOAD does nothing
      op("t4_clr", 1, 3'b110, 0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         op("t4_shl", 1, 3'b001, 1'($urandom_range(0, 1)), 8'h00);
         check($sformatf("t4_fd%0d", i), frame_done, (i == 7) ? 1'b1 : 1'b0);
         if (i < 7) begin
            held = par_out;
            for (int g = 0; g < 3; g++) begin
               op("t4_gap", 0, (g == 0) ? 3'b101 : 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
               check("t4_gap_hold", par_out, held);
            end
         end
      end

      // 5: LOAD discards a partial frame
      for (int i = 0; i < 5; i++) op("t5_pre", 1, 3'b001, 0, 8'h00);
      op("t5_load", 1, 3'b101, 0, 8'h3C);
      for (int i = 0; i < 7; i++) op("t5_shl", 1, 3'b010, 0, 8'h00);
      check("t5_fd7", frame_done, 1'b0);
      op("t5_shl8", 1, 3'b010, 0, 8'h00);
      check("t5_fd8", frame_done, 1'b1);

      // 6: asynchronous reset mid-frame
      op("t6_load", 1, 3'b101, 0, 8'hFF);
      for (int i = 0; i < 4; i++) op("t6_shl", 1, 3'b001, 0, 8'h00);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_q", par_out, 8'h00);
      check("t6_rst_fd", frame_done, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) op("t6_post", 1, 3'b001, 1, 8'h00);
      check("t6_fd7", frame_done, 1'b0);
      op("t6_post8", 1, 3'b001, 1, 8'h00);
      check("t6_fd8", frame_done, 1'b1);
      // reset while the pulse is high must drop it at once
      #2 rst = 1'b1;
      #1;
      check("t6_rst_pulse", frame_done, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Random operations against the model
      for (int i = 0; i < 400; i++) begin
         op("rnd", ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 5) != 0) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
